booth_divider: RTL and testbench
================================

Name: booth_divider

Overview:
- Sequential signed radix-2 restoring divider; it is the inverse-operation companion to the team's Booth multiplier.
- Takes a WIDTH-bit two's-complement dividend and divisor on a start request.
- Produces quotient and remainder after a fixed latency, with status flags.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.

Parameters:
- WIDTH, 4, operand/result width in bits (two's complement); legal range ≥ 2.
- CW, $clog2(WIDTH), derived; width of the iteration counter.

Ports:
- clk  input  1  single system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising clk edge.
- dividend  input  WIDTH  signed dividend; sampled with start.
- divisor  input  WIDTH  signed divisor; sampled with start.
- quotient  output  WIDTH  signed quotient, registered.
- remainder  output  WIDTH  signed remainder, registered.
- busy  output  1  high while an operation is in flight.
- done  output  1  high while results are valid (level, held).
- div_by_zero  output  1  last result came from divisor == 0.
- overflow  output  1  last result was most-negative / -1.
- count  output  CW  current iteration index during CALC; 0 otherwise.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; quotient, remainder, busy, done, div_by_zero, overflow and count all go to 0. Deassertion needs no start; the block waits in IDLE.
- States: IDLE, CALC, FIX, DONE.
- Start acceptance, in IDLE or DONE with start=1 at a clk edge:
  - latch the operand signs;
  - take magnitudes as WIDTH-bit unsigned (|-2^(W-1)| = 2^(W-1) fits);
  - clear the partial remainder (WIDTH+1 bits) and count;
  - busy←1, done←0, then go to CALC.
  - quotient/remainder/flags keep their old values until FIX.
- start while in CALC or FIX is ignored; the current operation is unaffected.
- CALC, one restoring step per edge for exactly WIDTH edges:
  - shift {partial remainder, dividend magnitude} left 1;
  - trial-subtract the divisor magnitude;
  - if the result is non-negative, commit it and shift in quotient bit 1, else restore and shift in 0;
  - count increments 0..WIDTH-1; after step WIDTH-1, go to FIX.
- FIX, one edge; registers are written by priority:
  - divisor == 0: quotient←all ones, remainder←dividend, div_by_zero←1, overflow←0.
  - else dividend == -2^(W-1) and divisor == -1: quotient←-2^(W-1) (wraps), remainder←0, overflow←1, div_by_zero←0.
  - else quotient←magnitude quotient, negated if the operand signs differ; remainder←magnitude remainder, negated if the dividend is negative; both flags←0.
  - Then busy←0, done←1, count←0, go to DONE.
- DONE: outputs held stable; done stays 1 until the next accepted start or reset.
- Latency: start sampled at edge k; results and done are visible after edge k+WIDTH+1; busy is high from after edge k through edge k+WIDTH+1.
- Back-to-back: start asserted in DONE is accepted at that edge (done falls the same edge); throughput is one result per WIDTH+2 cycles.
- Holding start high continuously restarts at every DONE, giving one result per WIDTH+2 cycles. The bench must tolerate this.
- Operands need only be stable at the accepting edge; later changes have no effect.

Decomposition:
- Package booth_div_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2, S_DONE=2'd3;
  - the default WIDTH.
- One combinational sub-module, div_step, computes a single restoring iteration.
  - Inputs: partial remainder, dividend-shift register, divisor magnitude.
  - Outputs: next partial remainder, next shift register, quotient bit.
  - It is instantiated once inside booth_divider.

Test Plan (WIDTH=4; all values two's complement):
- Reset, then start with -7 / 3 → after 6 edges, done=1, quotient=4'b1110 (-2), remainder=4'b1111 (-1), flags 0; busy high for exactly those cycles, count steps 0,1,2,3.
- Back-to-back starts 5 / 4 then 5 / -5 (start held in DONE) → first result quotient=1, remainder=1; then done drops for 6 cycles; second result quotient=4'b1111 (-1), remainder=0.
- 6 / 0 → quotient=4'b1111, remainder=4'b0110, div_by_zero=1, overflow=0, same 6-edge latency.
- -8 / -1 → quotient=4'b1000, remainder=0, overflow=1, div_by_zero=0; a following 7 / 2 clears both flags, giving quotient=3, remainder=1.
- Pulse start during CALC with different operands → ignored; original result returned on schedule.
- Assert reset mid-CALC (between edges) → all outputs 0 immediately; after release, no activity until start; a fresh -6 / 4 gives quotient=4'b1111 (-1), remainder=4'b1110 (-2).

Source files
------------

// File: rtl/booth_div_pkg.sv
// Shared state encoding and default width for the signed sequential divider.
package booth_div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/booth_divider_div_step.sv
// One unsigned restoring-division iteration; purely combinational.
// The vacated shift-register LSB is left at 0 so the caller inserts qbit.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   prem,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH:0]   prem_next,
    output logic [WIDTH-1:0] shreg_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted    = (prem << 1) | {{WIDTH{1'b0}}, shreg[WIDTH-1]};
        trial      = shifted - {1'b0, dmag};
        // Sign bit of the trial result decides commit versus restore.
        qbit       = ~trial[WIDTH];
        prem_next  = qbit ? trial : shifted;
        shreg_next = shreg << 1;
    end

endmodule

// File: rtl/booth_divider.sv
// Signed restoring divider: result and done appear WIDTH+2 edges after start.
// No backpressure; start is only honoured in IDLE or DONE.
module booth_divider
    import booth_div_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [CW-1:0]    count
);

    state_t           state;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] shreg_next;
    logic             qbit;

    logic             neg_dvd;
    logic             neg_dvs;
    logic [WIDTH-1:0] min_neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign neg_dvd = dvd_q[WIDTH-1];
    assign neg_dvs = dvs_q[WIDTH-1];
    assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem       (prem),
        .shreg      (shreg),
        .dmag       (dmag),
        .prem_next  (prem_next),
        .shreg_next (shreg_next),
        .qbit       (qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            prem        <= '0;
            shreg       <= '0;
            dmag        <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        shreg <= mag(dividend);
                        dmag  <= mag(divisor);
                        prem  <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    prem  <= prem_next;
                    shreg <= shreg_next | WIDTH'(qbit);
                    if (count == CW'(WIDTH - 1)) begin
                        count <= '0;
                        state <= S_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FIX: begin
                    // shreg now holds the magnitude quotient, prem the magnitude remainder.
                    if (dvs_q == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_q;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (dvd_q == min_neg && dvs_q == '1) begin
                        quotient    <= min_neg;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end else begin
                        quotient    <= (neg_dvd ^ neg_dvs) ? -shreg : shreg;
                        remainder   <= neg_dvd ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    count <= '0;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: stimulus pushes integer-arithmetic expectations,
// a monitor pops and compares on every rising edge of done.
module tb_booth_divider;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        logic [31:0]  t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic          overflow;
    logic [CW-1:0] count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic done_d = 1'b0;
    exp_t sb[$];

    booth_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .count       (count)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed integer division truncating toward zero, plus the two special cases.
    task automatic push_exp(input int a, input int b, input int k);
        exp_t e;
        int   q;
        int   r;
        int   minv;
        minv = -(1 << (W - 1));
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 0) begin
            q    = -1;
            r    = a;
            e.dz = 1'b1;
        end else if (a == minv && b == -1) begin
            q    = minv;
            r    = 0;
            e.ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        e.q = q[W-1:0];
        e.r = r[W-1:0];
        e.t = 32'(k + W + 1);
        sb.push_back(e);
    endtask

    function automatic int rnd_op();
        logic [W-1:0] t;
        t = W'($urandom);
        return int'($signed(t));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done && !done_d) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("latency", 32'(cyc), e.t);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        done_d = done;
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    // mode 0: plain; 1: trace busy/count per cycle; 2: poke start with other operands mid-CALC.
    task automatic do_op(input int a, input int b, input int mode);
        @(negedge clk);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        push_exp(a, b, cyc + 1);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (mode != 0) begin
            for (int i = 0; i <= W; i++) begin
                if (i > 0) @(negedge clk);
                if (mode == 1) begin
                    chk("trace_count", 32'(count), (i < W) ? 32'(i) : 32'd0);
                    chk("trace_busy", 32'(busy), 32'd1);
                    chk("trace_done", 32'(done), 32'd0);
                end
                if (mode == 2) begin
                    start    = (i == 1);
                    dividend = 4'd7;
                    divisor  = 4'd1;
                end
            end
            start = 1'b0;
            @(negedge clk);
            if (mode == 1) chk("trace_busy_low", 32'(busy), 32'd0);
        end
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #12;
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        do_op(-7, 3, 1);

        // Start held high through DONE: second operation accepted the same edge done falls.
        @(negedge clk);
        dividend = 4'd5;
        divisor  = 4'd4;
        start    = 1'b1;
        k = cyc + 1;
        push_exp(5, 4, k);
        @(negedge clk);
        dividend = 4'd5;
        divisor  = -4'sd5;
        push_exp(5, -5, k + W + 2);
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();

        do_op(6, 0, 0);
        do_op(-8, -1, 0);
        do_op(7, 2, 0);
        do_op(3, 3, 2);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        dividend = 4'd3;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {quotient, remainder, busy, done, div_by_zero, overflow, count},
            32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {29'd0, busy, done, 1'b0}, 32'd0);
        end
        do_op(-6, 4, 0);

        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = rnd_op();
            b = ($urandom_range(0, 7) == 0) ? 0 : rnd_op();
            if ($urandom_range(0, 7) == 0) begin
                a = -(1 << (W - 1));
                b = -1;
            end
            do_op(a, b, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
